// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared constants for the pattern shifter tile
//
// Purpose : step-operation encodings and default parameter values used by
//           pattern_shifter, step_prescaler and their benches.
// Ports   : none (package)

package pattern_pkg;

  // Default pattern width and step-divider width.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV_W = 16;

  // Step operation applied to the pattern on every divider tick.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,  // pattern unchanged, blink phase still advances
    MODE_ROL  = 2'b01,  // rotate left
    MODE_ROR  = 2'b10,  // rotate right
    MODE_SHL  = 2'b11   // shift left, ser_in enters at bit 0
  } mode_e;

endpackage

// File: rtl/step_prescaler.sv
// rtl/step_prescaler.sv - programmable step-period divider
//
// Purpose : counts enabled cycles and pulses tick once every div+1 of them.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           en    - count enable; 0 freezes the counter
//           clr   - synchronous clear, wins over en, suppresses tick
//           div   - step period minus one (0 = tick every enabled cycle)
//           tick  - combinational, high in the cycle whose edge is a step

module step_prescaler
  import pattern_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_reached;
  logic [DIV_W-1:0] w_cnt_inc;

  // Greater-or-equal rather than equality: if div is lowered below the
  // current count, the next enabled edge ticks instead of running the
  // counter all the way round its full range.
  assign w_reached = (r_cnt >= div);
  assign w_cnt_inc = r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
  assign tick      = en && !clr && w_reached;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_reached ? '0 : w_cnt_inc;
    end
  end

endmodule

// File: rtl/pattern_shifter.sv
// rtl/pattern_shifter.sv - loadable rotate/shift pattern register with blink
//
// Purpose : holds a WIDTH-bit display pattern that is parallel loaded and then
//           advanced one position per divider tick; optionally blanks the
//           display on alternate steps.
// Ports   : clk       - clock, rising edge
//           rst_n     - asynchronous active-low reset
//           en        - run enable; 0 freezes divider and pattern
//           load      - parallel load request (ignores en, beats tick)
//           load_data - pattern to load
//           mode      - step operation (see pattern_pkg::mode_e)
//           ser_in    - serial input for shift-left mode
//           div       - step period minus one
//           blink     - 1 = blank display on alternate steps
//           q         - current pattern
//           disp      - display pattern (q, or 0 during blank phase)
//           step      - one-cycle pulse in the cycle after each advance

module pattern_shifter
  import pattern_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic [DIV_W-1:0] div,
  input  logic             blink,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] disp,
  output logic             step
);

  logic [WIDTH-1:0] r_q;
  logic             r_ph;    // blink phase: 1 = display shown, 0 = blanked
  logic             r_step;
  logic             w_tick;
  logic [WIDTH-1:0] w_next;

  step_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .div   (div),
    .tick  (w_tick)
  );

  always_comb begin
    w_next = r_q;
    case (mode_e'(mode))
      MODE_HOLD: w_next = r_q;
      MODE_ROL:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      MODE_ROR:  w_next = {r_q[0], r_q[WIDTH-1:1]};
      MODE_SHL:  w_next = {r_q[WIDTH-2:0], ser_in};
      default:   w_next = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_ph   <= 1'b1;
      r_step <= 1'b0;
    end else if (load) begin
      r_q    <= load_data;
      r_ph   <= 1'b1;
      r_step <= 1'b0;
    end else if (w_tick) begin
      // Hold mode still counts as a step so the blink keeps its rate.
      r_q    <= w_next;
      r_ph   <= ~r_ph;
      r_step <= 1'b1;
    end else begin
      r_step <= 1'b0;
    end
  end

  // Blanking is a plain mux of registered state, so no clock reaches the
  // output pins and disp cannot glitch on clock edges.
  assign q    = r_q;
  assign disp = (blink && !r_ph) ? '0 : r_q;
  assign step = r_step;

endmodule

// File: tb/tb_pattern_shifter.sv
// tb/tb_pattern_shifter.sv - self-checking bench for pattern_shifter

module tb_pattern_shifter;
  import pattern_pkg::*;

  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          en        = 1'b0;
  logic          load      = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic [1:0]    mode      = 2'b00;
  logic          ser_in    = 1'b0;
  logic [DW-1:0] div       = '0;
  logic          blink     = 1'b0;
  logic [W-1:0]  q;
  logic [W-1:0]  disp;
  logic          step;

  always #5 clk = ~clk;

  pattern_shifter #(
    .WIDTH (W),
    .DIV_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .load_data (load_data),
    .mode      (mode),
    .ser_in    (ser_in),
    .div       (div),
    .blink     (blink),
    .q         (q),
    .disp      (disp),
    .step      (step)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state, advanced once per clock by clk_cycle.
  logic [W-1:0] m_q;
  int           m_cnt;
  logic         m_ph;
  logic         m_step;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] disp;
    logic         step;
  } exp_t;

  exp_t sb[$];

  task automatic model_reset();
    m_q    = '0;
    m_cnt  = 0;
    m_ph   = 1'b1;
    m_step = 1'b0;
  endtask

  // Predict the post-edge outputs from the current inputs, queue them, then
  // clock the DUT and compare against the oldest queued expectation.
  task automatic clk_cycle(input string tag);
    exp_t e;
    if (load) begin
      m_q = load_data; m_cnt = 0; m_ph = 1'b1; m_step = 1'b0;
    end else if (en) begin
      if (m_cnt >= int'(div)) begin
        case (mode)
          MODE_ROL: m_q = {m_q[W-2:0], m_q[W-1]};
          MODE_ROR: m_q = {m_q[0], m_q[W-1:1]};
          MODE_SHL: m_q = {m_q[W-2:0], ser_in};
          default:  m_q = m_q;
        endcase
        m_cnt = 0; m_ph = ~m_ph; m_step = 1'b1;
      end else begin
        m_cnt++; m_step = 1'b0;
      end
    end else begin
      m_step = 1'b0;
    end
    e.q    = m_q;
    e.step = m_step;
    e.disp = (blink && !m_ph) ? '0 : m_q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".q"},    q,    e.q);
    check({tag, ".disp"}, disp, e.disp);
    check({tag, ".step"}, step, e.step);
  endtask

  initial begin
    logic [W-1:0] one;
    int           steps;
    int           sbits[4];
    one   = 8'h01;
    sbits = '{1, 0, 1, 1};

    // Reset state.
    model_reset();
    #3;
    check("rst.q", q, 0);
    check("rst.disp", disp, 0);
    check("rst.step", step, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Rotate left every cycle.
    load = 1'b1; load_data = 8'h01; mode = MODE_ROL; div = 0; en = 1'b1;
    clk_cycle("rol_load");
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      clk_cycle("rol");
      check("rol_seq", q, one << (k % 8));
      check("rol_step_high", step, 1);
    end

    // Rotate right with div=3.
    load = 1'b1; load_data = 8'h81; mode = MODE_ROR; div = 3;
    clk_cycle("ror_load");
    load = 1'b0;
    steps = 0;
    for (int k = 1; k <= 8; k++) begin
      clk_cycle("ror");
      steps += int'(step);
      if (k == 4) check("ror_first", q, 8'hC0);
      if (k == 8) check("ror_second", q, 8'h60);
    end
    check("ror_step_count", steps, 2);

    // Shift left with serial input 1,0,1,1.
    load = 1'b1; load_data = 8'h00; mode = MODE_SHL; div = 0;
    clk_cycle("shl_load");
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ser_in = sbits[i][0];
      clk_cycle("shl");
    end
    check("shl_result", q, 8'h0B);
    ser_in = 1'b0;

    // Blink at step rate with div=1.
    blink = 1'b1; load = 1'b1; load_data = 8'hFF; mode = MODE_HOLD; div = 1;
    clk_cycle("blink_load");
    load = 1'b0;
    check("blink_k0", disp, 8'hFF);
    for (int k = 1; k < 8; k++) begin
      clk_cycle("blink");
      check("blink_disp", disp, ((k / 2) % 2 == 0) ? 8'hFF : 8'h00);
      check("blink_q", q, 8'hFF);
    end
    blink = 1'b0;

    // Lowering div mid-count ticks at once, then every div+1 cycles.
    load = 1'b1; load_data = 8'h3C; div = 100;
    clk_cycle("div_load");
    load = 1'b0;
    for (int k = 0; k < 50; k++) clk_cycle("div_hi");
    div = 10;
    clk_cycle("div_drop");
    check("div_drop_tick", step, 1);
    steps = 0;
    for (int k = 0; k < 10; k++) begin
      clk_cycle("div_gap");
      steps += int'(step);
    end
    check("div_gap_quiet", steps, 0);
    clk_cycle("div_next");
    check("div_next_tick", step, 1);

    // Asynchronous reset mid-count.
    load = 1'b1; load_data = 8'h5A; mode = MODE_ROL; div = 20;
    clk_cycle("arst_load");
    load = 1'b0;
    for (int k = 0; k < 5; k++) clk_cycle("arst_run");
    check("arst_pre_q", q, 8'h5A);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.q", q, 0);
    check("arst.disp", disp, 0);
    check("arst.step", step, 0);
    #1;
    rst_n = 1'b1;
    div = 2;
    for (int k = 0; k < 4; k++) clk_cycle("post_rst");

    // Load while disabled still loads; pattern then holds.
    en = 1'b0; load = 1'b1; load_data = 8'hA5; div = 0;
    clk_cycle("dis_load");
    load = 1'b0;
    for (int k = 0; k < 5; k++) clk_cycle("dis_hold");
    check("dis_hold_q", q, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_shifter.md
# pattern_shifter

Parametrised pattern register for LED/bar-display tiles. It holds a WIDTH-bit pattern that is parallel-loaded, then rotated or shifted one position per programmable step tick. The display output can blink at the step rate. It sits between the user-input decode and the output pins of a display tile, replacing the fixed 4-bit rotate-with-load register and the clock-gated output enable.

## Interface
Parameters:
- WIDTH, 8, pattern width in bits (≥2)
- DIV_W, 16, width of the step-period divider

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 freezes divider and pattern
- load  in  1  synchronous parallel load request
- load_data  in  WIDTH  pattern to load
- mode  in  2  step operation: 00 hold, 01 rotate left, 10 rotate right, 11 shift left with ser_in
- ser_in  in  1  serial input for mode 11
- div  in  DIV_W  step period minus one (0 = step every cycle)
- blink  in  1  1 = blink display at step rate
- q  out  WIDTH  current pattern
- disp  out  WIDTH  display pattern (q, or 0 in blank phase)
- step  out  1  one-cycle pulse, cycle after each pattern advance

## Operation
- Reset (async, rst_n=0): q=0, divider cnt=0, blink phase ph=1, step=0, so disp=0.
- Divider: when en=1 and not load, cnt increments. When cnt ≥ div, tick=1 and cnt←0. The ≥ compare keeps a lowered div from wrapping the full range.
- Tick action on q, by mode: 00 unchanged; 01 {q[W-2:0],q[W-1]}; 10 {q[0],q[W-1:1]}; 11 {q[W-2:0],ser_in}, with ser_in sampled on the tick edge.
- Every tick, including mode 00, toggles ph and registers step=1 for the next cycle.
- Load has priority over tick and ignores en: q←load_data, cnt←0, ph←1, no step pulse.
- en=0 without load: cnt, q and ph hold; step=0.
- disp = (blink && !ph) ? 0 : q. Combinational from registers only, glitch-free; no clock in the datapath.
- mode, div and blink may change at any time and take effect from the next edge.

## Timing
- Load: q=load_data visible one cycle after the load edge.
- Step period: div+1 enabled cycles between successive q advances.
- step asserts in the cycle after the edge that advanced q, for one cycle.
- First advance after a load occurs div+1 enabled cycles after the load edge.
- div=0 with en=1: q advances every edge; step is held high continuously.
- Reset asserted mid-sequence clears all state immediately. First tick after release comes div+1 edges after release.

## Structure
- Shared package pattern_pkg:
  - mode constants MODE_HOLD=2'b00, MODE_ROL=2'b01, MODE_ROR=2'b10, MODE_SHL=2'b11
  - default parameter values
- Sub-module step_prescaler (clk, rst_n, en, clr, div → tick) holds the ≥-compare counter.
- pattern_shifter holds the q register, ph, step and the disp mux.

## Test plan
- Reset, then load 0x01, mode 01, div=0, en=1 → q sequence 0x02,0x04,…,0x80,0x01 on consecutive cycles; step high throughout.
- Load 0x81, mode 10, div=3 → q becomes 0xC0 four cycles after load, then 0x60 four cycles later; step pulses exactly once per 4 cycles.
- Mode 11, ser_in pattern 1,0,1,1 over four ticks from q=0x00 with div=0 → q=0x0B.
- blink=1, load 0xFF, mode 00, div=1 → disp alternates 0xFF/0x00 every 2 cycles; q stays 0xFF.
- Set div=100, run to cnt≈50, then set div=10 → tick on the next edge, then every 11 cycles; no 2^16-cycle stall.
- Assert rst_n=0 mid-count with q=0x5A → q, disp, step are 0 immediately. Load asserted during en=0 still loads, and q holds afterwards.
